// File: rtl/sramlike_pkg.sv
// rtl/sramlike_pkg.sv - shared types and constants for the sram-like bus arbiter
package sramlike_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [3:0] STARVE_MAX = 4'd15;

  // Increment that sticks at STARVE_MAX instead of wrapping to zero.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == STARVE_MAX) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/sramlike_starve_ctr.sv
// rtl/sramlike_starve_ctr.sv - counts inst's lost arbitrations and raises its priority override
module sramlike_starve_ctr
  import sramlike_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic grant_inst,
  input  logic grant_data_contended,
  output logic inst_override
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] cnt;

  // An inst grant clears the count; a data grant that beat a waiting inst bumps it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (grant_inst) begin
      cnt <= 4'd0;
    end else if (grant_data_contended) begin
      cnt <= sat_inc4(cnt);
    end
  end

  assign inst_override = (cnt >= LIMIT);

endmodule

// File: rtl/sramlike_bus_arbiter.sv
// rtl/sramlike_bus_arbiter.sv - inst/data sram-like arbiter onto one slave port; SRAMLIKE_ARB_PERF_EN adds perf counters
module sramlike_bus_arbiter
  import sramlike_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic              m_req,
  output logic              m_wr,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok
`ifdef SRAMLIKE_ARB_PERF_EN
  ,
  output logic [31:0]       perf_inst_grants,
  output logic [31:0]       perf_data_grants,
  output logic [31:0]       perf_conflicts
`endif
);

  arb_state_e state, state_next;
  logic       owner, owner_next;
  logic       inst_override;
  logic       sel_data;
  logic       grant;

  // Data wins unless inst has lost too many times in a row and is still waiting.
  assign sel_data = data_req & ~(inst_req & inst_override);
  assign grant    = (state == ARB_IDLE) & m_req & m_addr_ok;

  // Read data is broadcast; each master only samples it on its own data_ok.
  assign inst_rdata = m_rdata;
  assign data_rdata = m_rdata;

  sramlike_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk                 (clk),
    .rst                 (rst),
    .grant_inst          (grant & ~sel_data),
    .grant_data_contended(grant & sel_data & inst_req),
    .inst_override       (inst_override)
  );

  // State and transaction owner registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      owner <= OWN_INST;
    end else begin
      state <= state_next;
      owner <= owner_next;
    end
  end

  // Address-phase muxing in IDLE, response routing in BUSY.
  always_comb begin
    state_next   = state;
    owner_next   = owner;
    m_req        = 1'b0;
    m_wr         = 1'b0;
    m_size       = SIZE_BYTE;
    m_addr       = '0;
    m_wdata      = '0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (sel_data) begin
          m_req        = data_req;
          m_wr         = data_wr;
          m_size       = data_size;
          m_addr       = data_addr;
          m_wdata      = data_wdata;
          data_addr_ok = m_addr_ok & data_req;
        end else begin
          m_req        = inst_req;
          m_wr         = inst_wr;
          m_size       = inst_size;
          m_addr       = inst_addr;
          m_wdata      = inst_wdata;
          inst_addr_ok = m_addr_ok & inst_req;
        end
        if (m_req & m_addr_ok) begin
          state_next = ARB_BUSY;
          owner_next = sel_data ? OWN_DATA : OWN_INST;
        end
      end
      ARB_BUSY: begin
        if (owner == OWN_DATA) begin
          data_data_ok = m_data_ok;
        end else begin
          inst_data_ok = m_data_ok;
        end
        if (m_data_ok) begin
          state_next = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

`ifdef SRAMLIKE_ARB_PERF_EN
  // Grant and contention counters, free-running modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_inst_grants <= 32'd0;
      perf_data_grants <= 32'd0;
      perf_conflicts   <= 32'd0;
    end else begin
      if (grant & ~sel_data) perf_inst_grants <= perf_inst_grants + 32'd1;
      if (grant & sel_data)  perf_data_grants <= perf_data_grants + 32'd1;
      if ((state == ARB_IDLE) & inst_req & data_req) perf_conflicts <= perf_conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sramlike_bus_arbiter.sv
// tb/tb_sramlike_bus_arbiter.sv - directed self-checking bench for sramlike_bus_arbiter
module tb_sramlike_bus_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [31:0] inst_rdata, data_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_addr_ok, m_data_ok;
`ifdef SRAMLIKE_ARB_PERF_EN
  logic [31:0] perf_inst_grants, perf_data_grants, perf_conflicts;
`endif

  int errors = 0;
  int checks = 0;

  sramlike_bus_arbiter #(
    .STARVE_LIMIT(LIMIT),
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok)
`ifdef SRAMLIKE_ARB_PERF_EN
    ,
    .perf_inst_grants(perf_inst_grants),
    .perf_data_grants(perf_data_grants),
    .perf_conflicts(perf_conflicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'b10; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'b10; data_addr = 0; data_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 32'h0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1;
    step(); step();
    rst = 0;
  endtask

  initial begin
    logic exp_data;
    int   exp_cnt;

    idle_inputs();
    rst = 1;
    m_rdata = 32'h5a5a1234;
    step(); settle();
    check("reset_m_req", {31'd0, m_req}, 32'd0);
    check("reset_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
    check("reset_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    check("reset_rdata_follow", data_rdata, 32'h5a5a1234);
    rst = 0;

    // Single inst read, data_ok three cycles after addr_ok.
    step();
    inst_req = 1; inst_addr = 32'hbfc00000; m_addr_ok = 1;
    settle();
    check("t1_m_req", {31'd0, m_req}, 32'd1);
    check("t1_m_addr", m_addr, 32'hbfc00000);
    check("t1_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    check("t1_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    step();
    inst_req = 0; m_addr_ok = 0; settle();
    check("t1_busy_m_req", {31'd0, m_req}, 32'd0);
    check("t1_c1_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    step(); settle();
    check("t1_c2_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    step();
    m_data_ok = 1; m_rdata = 32'h3c1d0000; settle();
    check("t1_c3_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
    check("t1_c3_data_data_ok", {31'd0, data_data_ok}, 32'd0);
    check("t1_c3_inst_rdata", inst_rdata, 32'h3c1d0000);
    step();
    m_data_ok = 0; settle();
    check("t1_c4_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);

    // Simultaneous requests: data wins, then inst on the next IDLE cycle.
    step();
    inst_req = 1; inst_addr = 32'hbfc00010;
    data_req = 1; data_addr = 32'h80001000; m_addr_ok = 1; settle();
    check("t2_m_addr", m_addr, 32'h80001000);
    check("t2_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    check("t2_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    step();
    data_req = 0; m_addr_ok = 0; m_data_ok = 1; settle();
    check("t2_data_data_ok", {31'd0, data_data_ok}, 32'd1);
    check("t2_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    check("t2_busy_m_req", {31'd0, m_req}, 32'd0);
    step();
    m_data_ok = 0; m_addr_ok = 1; settle();
    check("t2_inst_grant", {31'd0, inst_addr_ok}, 32'd1);
    check("t2_inst_m_addr", m_addr, 32'hbfc00010);
    step();
    inst_req = 0; m_addr_ok = 0; m_data_ok = 1; settle();
    check("t2_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
    step();
    m_data_ok = 0;

    // Data write: every field passes through to the slave.
    data_req = 1; data_wr = 1; data_size = 2'b01;
    data_addr = 32'h80000002; data_wdata = 32'h0000beef; m_addr_ok = 1; settle();
    check("t4_m_wr", {31'd0, m_wr}, 32'd1);
    check("t4_m_size", {30'd0, m_size}, 32'd1);
    check("t4_m_addr", m_addr, 32'h80000002);
    check("t4_m_wdata", m_wdata, 32'h0000beef);
    check("t4_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    step();
    data_req = 0; data_wr = 0; m_addr_ok = 0; m_data_ok = 1; settle();
    check("t4_data_data_ok", {31'd0, data_data_ok}, 32'd1);
    step();
    m_data_ok = 0; settle();
    check("t4_data_ok_once", {31'd0, data_data_ok}, 32'd0);

    // Spurious data_ok in IDLE is ignored.
    m_data_ok = 1; settle();
    check("spurious_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    step();
    m_data_ok = 0;

    // Reset one cycle after addr_ok drops the outstanding response.
    inst_req = 1; inst_addr = 32'hbfc00020; m_addr_ok = 1; settle();
    check("t5_grant", {31'd0, inst_addr_ok}, 32'd1);
    step();
    inst_req = 0; m_addr_ok = 0; rst = 1; m_data_ok = 1; settle();
    check("t5_rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    step();
    rst = 0; m_data_ok = 0;
    step();
    inst_req = 1; inst_addr = 32'hbfc00030; m_addr_ok = 1; settle();
    check("t5_first_cycle_grant", {31'd0, inst_addr_ok}, 32'd1);
    check("t5_m_addr", m_addr, 32'hbfc00030);
    step();
    inst_req = 0; m_addr_ok = 0; m_data_ok = 1;
    step();
    m_data_ok = 0;

    // Starvation: both masters request continuously, 1-cycle slave latency.
    apply_reset();
    step();
    inst_req = 1; inst_addr = 32'hbfc00040;
    data_req = 1; data_addr = 32'h80002000;
    exp_cnt = 0;
    for (int g = 0; g < 10; g++) begin
      exp_data = (exp_cnt < LIMIT);
      m_addr_ok = 1; m_data_ok = 0; settle();
      check($sformatf("t3_g%0d_data_addr_ok", g), {31'd0, data_addr_ok}, {31'd0, exp_data});
      check($sformatf("t3_g%0d_inst_addr_ok", g), {31'd0, inst_addr_ok}, {31'd0, ~exp_data});
      exp_cnt = exp_data ? exp_cnt + 1 : 0;
      step();
      m_addr_ok = 0; m_data_ok = 1; settle();
      check($sformatf("t3_g%0d_data_ok", g), {30'd0, inst_data_ok, data_data_ok},
            exp_data ? 32'd1 : 32'd2);
      step();
    end
    inst_req = 0; data_req = 0; m_data_ok = 0; settle();
`ifdef SRAMLIKE_ARB_PERF_EN
    check("perf_data_grants", perf_data_grants, 32'd8);
    check("perf_inst_grants", perf_inst_grants, 32'd2);
    check("perf_conflicts_ge10", {31'd0, perf_conflicts >= 32'd10}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
